// File: rtl/dpr_pingpong_mem.sv
// Dual-port word memory with optional ping-pong banks and a commit/lock swap handshake.
// Latency: 1-cycle read and write, read-first; no backpressure, the swap is deferred while B_LOCK is high.
module dpr_pingpong_mem #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int PINGPONG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DIN,
    input  logic              A_WEN,
    output logic [DATA_W-1:0] A_DOUT,
    input  logic              A_COMMIT,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DIN,
    input  logic              B_WEN,
    output logic [DATA_W-1:0] B_DOUT,
    input  logic              B_LOCK,
    input  logic              B_ACK,
    output logic              BANK_SEL,
    output logic              SWAP_PEND,
    output logic              B_FRESH,
    output logic              OVERRUN,
    output logic              COLLISION
);

    localparam bit PP    = (PINGPONG != 0);
    localparam int IDX_W = PP ? ADDR_W + 1 : ADDR_W;
    localparam int WORDS = 1 << IDX_W;

    logic [DATA_W-1:0] mem [WORDS];
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;
    logic              swap_now;
    logic              pend_set;
    logic              ovr_set;
    logic              col_nxt;

    generate
        if (PP) begin : g_pingpong
            assign a_idx = {BANK_SEL, A_ADDR};
            assign b_idx = {~BANK_SEL, B_ADDR};
        end else begin : g_shared
            assign a_idx = A_ADDR;
            assign b_idx = B_ADDR;
        end
    endgenerate

    // A pending swap fires on the first unlocked cycle; a commit never queues a second one.
    assign swap_now = PP && !B_LOCK && (SWAP_PEND || A_COMMIT);
    assign pend_set = PP && A_COMMIT && !SWAP_PEND && B_LOCK;
    assign ovr_set  = PP && A_COMMIT && SWAP_PEND;
    assign col_nxt  = !PP && A_WEN && B_WEN && (A_ADDR == B_ADDR);

    // Port A wins a same-word write; only possible in shared mode.
    always_ff @(posedge CLK) begin
        if (A_WEN) begin
            mem[a_idx] <= A_DIN;
        end
        if (B_WEN && !(A_WEN && (a_idx == b_idx))) begin
            mem[b_idx] <= B_DIN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A_DOUT <= '0;
            B_DOUT <= '0;
        end else begin
            A_DOUT <= mem[a_idx];
            B_DOUT <= mem[b_idx];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BANK_SEL  <= 1'b0;
            SWAP_PEND <= 1'b0;
            B_FRESH   <= 1'b0;
            OVERRUN   <= 1'b0;
            COLLISION <= 1'b0;
        end else begin
            COLLISION <= col_nxt;
            if (swap_now) begin
                BANK_SEL  <= ~BANK_SEL;
                SWAP_PEND <= 1'b0;
            end else if (pend_set) begin
                SWAP_PEND <= 1'b1;
            end
            if (swap_now) begin
                B_FRESH <= 1'b1;
            end else if (B_ACK) begin
                B_FRESH <= 1'b0;
            end
            if (ovr_set) begin
                OVERRUN <= 1'b1;
            end else if (B_ACK) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dpr_pingpong_mem.sv
// Bench for dpr_pingpong_mem: one ping-pong instance and one shared-mode instance,
// driven by a control table, directed corner sequences and random traffic against a model.
module tb_dpr_pingpong_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_din, b_din;
    logic        a_wen, b_wen, a_commit, b_lock, b_ack;
    logic [15:0] a_dout, b_dout;
    logic        bank_sel, swap_pend, b_fresh, overrun, collision;

    logic [4:0]  s_a_addr, s_b_addr;
    logic [15:0] s_a_din, s_b_din;
    logic        s_a_wen, s_b_wen, s_a_commit, s_b_lock, s_b_ack;
    logic [15:0] s_a_dout, s_b_dout;
    logic        s_bank_sel, s_swap_pend, s_b_fresh, s_overrun, s_collision;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dpr_pingpong_mem #(.DATA_W(16), .ADDR_W(5), .PINGPONG(1)) u_pp (
        .CLK(clk), .RST(rst),
        .A_ADDR(a_addr), .A_DIN(a_din), .A_WEN(a_wen), .A_DOUT(a_dout), .A_COMMIT(a_commit),
        .B_ADDR(b_addr), .B_DIN(b_din), .B_WEN(b_wen), .B_DOUT(b_dout),
        .B_LOCK(b_lock), .B_ACK(b_ack),
        .BANK_SEL(bank_sel), .SWAP_PEND(swap_pend), .B_FRESH(b_fresh),
        .OVERRUN(overrun), .COLLISION(collision)
    );

    dpr_pingpong_mem #(.DATA_W(16), .ADDR_W(5), .PINGPONG(0)) u_sh (
        .CLK(clk), .RST(rst),
        .A_ADDR(s_a_addr), .A_DIN(s_a_din), .A_WEN(s_a_wen), .A_DOUT(s_a_dout), .A_COMMIT(s_a_commit),
        .B_ADDR(s_b_addr), .B_DIN(s_b_din), .B_WEN(s_b_wen), .B_DOUT(s_b_dout),
        .B_LOCK(s_b_lock), .B_ACK(s_b_ack),
        .BANK_SEL(s_bank_sel), .SWAP_PEND(s_swap_pend), .B_FRESH(s_b_fresh),
        .OVERRUN(s_overrun), .COLLISION(s_collision)
    );

    // Reference model: two word arrays plus the handshake flags, updated once per edge.
    logic [15:0] m_mem [2][32];
    logic [15:0] m_smem [32];
    logic [15:0] m_adout, m_bdout, m_sadout, m_sbdout;
    bit          m_sel, m_pend, m_fresh, m_ovr, m_scol;

    task automatic model_reset();
        m_sel = 0; m_pend = 0; m_fresh = 0; m_ovr = 0; m_scol = 0;
        m_adout = 0; m_bdout = 0; m_sadout = 0; m_sbdout = 0;
    endtask

    task automatic model_edge();
        bit fill, do_swap, n_pend, n_fresh, n_ovr;
        fill = m_sel;
        m_adout = m_mem[fill][a_addr];
        m_bdout = m_mem[!fill][b_addr];
        if (a_wen) m_mem[fill][a_addr] = a_din;
        if (b_wen) m_mem[!fill][b_addr] = b_din;
        do_swap = 0; n_pend = m_pend; n_fresh = m_fresh; n_ovr = m_ovr;
        if (b_ack) begin n_fresh = 0; n_ovr = 0; end
        if (a_commit) begin
            if (m_pend) n_ovr = 1;
            else if (b_lock) n_pend = 1;
            else do_swap = 1;
        end
        if (m_pend && !b_lock) do_swap = 1;
        if (do_swap) begin m_sel = !m_sel; n_pend = 0; n_fresh = 1; end
        m_pend = n_pend; m_fresh = n_fresh; m_ovr = n_ovr;
        m_sadout = m_smem[s_a_addr];
        m_sbdout = m_smem[s_b_addr];
        m_scol = s_a_wen && s_b_wen && (s_a_addr == s_b_addr);
        if (s_b_wen) m_smem[s_b_addr] = s_b_din;
        if (s_a_wen) m_smem[s_a_addr] = s_a_din;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        a_addr = 0; a_din = 0; a_wen = 0; a_commit = 0;
        b_addr = 0; b_din = 0; b_wen = 0; b_lock = 0; b_ack = 0;
        s_a_addr = 0; s_a_din = 0; s_a_wen = 0; s_a_commit = 0;
        s_b_addr = 0; s_b_din = 0; s_b_wen = 0; s_b_lock = 0; s_b_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_dout"}, a_dout, 0);
        chk({tag, "_b_dout"}, b_dout, 0);
        chk({tag, "_flags"}, {bank_sel, swap_pend, b_fresh, overrun, collision}, 0);
        chk({tag, "_s_dout"}, {s_a_dout, s_b_dout}, 0);
        chk({tag, "_s_flags"}, {s_bank_sel, s_swap_pend, s_b_fresh, s_overrun, s_collision}, 0);
    endtask

    task automatic chk_model();
        chk("rnd_a_dout", a_dout, m_adout);
        chk("rnd_b_dout", b_dout, m_bdout);
        chk("rnd_flags", {bank_sel, swap_pend, b_fresh, overrun, collision},
            {m_sel, m_pend, m_fresh, m_ovr, 1'b0});
        chk("rnd_s_a_dout", s_a_dout, m_sadout);
        chk("rnd_s_b_dout", s_b_dout, m_sbdout);
        chk("rnd_s_flags", {s_bank_sel, s_swap_pend, s_b_fresh, s_overrun, s_collision},
            {4'b0000, m_scol});
    endtask

    typedef struct {
        bit commit, lock, ack;
        bit sel, pend, fresh, ovr;
    } ctl_vec_t;

    ctl_vec_t tbl [17];

    initial begin
        // {commit, lock, ack} -> {BANK_SEL, SWAP_PEND, B_FRESH, OVERRUN} after the edge
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 1, 0};
        tbl[2]  = '{0, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 1, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 1, 0, 0};
        tbl[10] = '{1, 0, 0, 1, 0, 1, 1};
        tbl[11] = '{1, 0, 1, 0, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 1, 0};
        tbl[13] = '{0, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 0, 1, 0, 0};
        tbl[15] = '{1, 1, 1, 0, 1, 0, 1};
        tbl[16] = '{0, 0, 1, 1, 0, 1, 0};

        clear_inputs();
        model_reset();
        #1;
        chk_all_zero("reset_async");
        @(posedge clk);
        #1;
        rst = 0;
        chk_all_zero("reset_state");

        for (int i = 0; i < 17; i++) begin
            a_commit = tbl[i].commit;
            b_lock   = tbl[i].lock;
            b_ack    = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d", i), {bank_sel, swap_pend, b_fresh, overrun},
                {tbl[i].sel, tbl[i].pend, tbl[i].fresh, tbl[i].ovr});
        end
        clear_inputs();

        // Fill bank 0, commit, read it back through port B.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            a_wen = 1; a_addr = 5'(i); a_din = 16'hA000 + 16'(i);
            tick();
        end
        a_wen = 0; a_commit = 1;
        tick();
        a_commit = 0;
        chk("fill_sel_fresh", {bank_sel, b_fresh}, 2'b11);
        for (int i = 0; i < 32; i++) begin
            b_addr = 5'(i);
            tick();
            chk($sformatf("fill_rd%0d", i), b_dout, 16'hA000 + 16'(i));
        end

        // Commit-cycle write lands in the committed buffer; B read in that cycle sees old data.
        b_ack = 1; tick(); b_ack = 0;
        a_wen = 1; a_addr = 7; a_din = 16'h1234; a_commit = 1; b_addr = 5;
        tick();
        a_wen = 0; a_commit = 0;
        chk("cc_sel", bank_sel, 0);
        chk("cc_old_b", b_dout, 16'hA005);
        b_addr = 7;
        tick();
        chk("cc_new_b", b_dout, 16'h1234);
        b_ack = 1; tick(); b_ack = 0;

        // Deferred swap held by a 10-cycle lock.
        b_lock = 1; a_commit = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            a_commit = 0;
            chk($sformatf("defer%0d", i), {bank_sel, swap_pend}, 2'b01);
        end
        b_lock = 0;
        tick();
        chk("defer_release", {bank_sel, swap_pend, b_fresh}, 3'b101);

        // Two commits under lock: overrun, exactly one swap, then acknowledge.
        b_ack = 1; tick(); b_ack = 0;
        b_lock = 1; a_commit = 1;
        tick(); tick();
        a_commit = 0;
        chk("ovr_set", {bank_sel, swap_pend, overrun}, 3'b111);
        b_lock = 0;
        tick();
        chk("ovr_swap", {bank_sel, swap_pend}, 2'b00);
        tick();
        chk("ovr_one_swap", bank_sel, 0);
        b_ack = 1;
        tick();
        b_ack = 0;
        chk("ovr_ack", {overrun, b_fresh}, 2'b00);

        // Read-first on port B of the ping-pong instance and across ports in shared mode.
        b_wen = 1; b_addr = 9; b_din = 16'h1111; tick();
        b_din = 16'hBEEF; tick();
        b_wen = 0;
        chk("rf_old", b_dout, 16'h1111);
        tick();
        chk("rf_new", b_dout, 16'hBEEF);
        s_a_wen = 1; s_a_addr = 4; s_a_din = 16'h2222; tick();
        s_a_din = 16'hBEEF; s_b_addr = 4; tick();
        s_a_wen = 0;
        chk("s_rf_old", s_b_dout, 16'h2222);
        tick();
        chk("s_rf_new", s_b_dout, 16'hBEEF);

        // Shared-mode write collision: A wins, pulse lasts one cycle.
        chk("s_col_idle", s_collision, 0);
        s_a_wen = 1; s_b_wen = 1; s_a_addr = 3; s_b_addr = 3;
        s_a_din = 16'h5555; s_b_din = 16'hAAAA;
        tick();
        s_a_wen = 0; s_b_wen = 0;
        chk("s_col_pulse", s_collision, 1);
        tick();
        chk("s_col_clear", s_collision, 0);
        chk("s_col_data", {s_a_dout, s_b_dout}, {16'h5555, 16'h5555});

        // Initialise every word, then random traffic against the model.
        for (int i = 0; i < 32; i++) begin
            a_wen = 1; a_addr = 5'(i); a_din = 16'($urandom);
            b_wen = 1; b_addr = 5'(i); b_din = 16'($urandom);
            s_a_wen = 1; s_a_addr = 5'(i); s_a_din = 16'($urandom);
            s_b_wen = 0;
            tick();
        end
        for (int n = 0; n < 1500; n++) begin
            a_addr = 5'($urandom); a_din = 16'($urandom); a_wen = 1'($urandom_range(0, 1));
            b_addr = 5'($urandom); b_din = 16'($urandom); b_wen = 1'($urandom_range(0, 1));
            a_commit = ($urandom_range(0, 7) == 0);
            b_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) b_lock = !b_lock;
            s_a_addr = 5'($urandom_range(0, 3)); s_a_din = 16'($urandom);
            s_b_addr = 5'($urandom_range(0, 3)); s_b_din = 16'($urandom);
            s_a_wen = 1'($urandom_range(0, 1)); s_b_wen = 1'($urandom_range(0, 1));
            s_a_commit = 1'($urandom_range(0, 1)); s_b_lock = 1'($urandom_range(0, 1));
            s_b_ack = 1'($urandom_range(0, 1));
            tick();
            chk_model();
        end

        // Asynchronous reset mid-cycle with a swap pending.
        clear_inputs();
        a_addr = 7; b_addr = 9; s_a_addr = 3; s_b_addr = 4;
        b_ack = 1; tick(); b_ack = 0;
        b_lock = 1; a_commit = 1;
        tick();
        a_commit = 0;
        chk("arst_pend_before", swap_pend, 1);
        #3;
        rst = 1;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        #1;
        rst = 0;
        b_lock = 0;
        tick();
        chk("arst_abandon", {bank_sel, swap_pend, b_fresh}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpr_pingpong_mem.md
# dpr_pingpong_mem

Parametrised successor to the single-bank dual-port word memory used between the MIL-STD-1553 protocol engine (port A) and the host/subsystem side (port B). It adds a ping-pong mode: the engine fills one bank while the host reads a stable, complete message from the other. A commit/lock handshake swaps the banks atomically. A shared mode keeps the original single-bank behaviour and adds write-collision detection.

## Interface
- DATA_W, 16, word width
- ADDR_W, 5, word address width per bank (depth 2^ADDR_W per bank)
- PINGPONG, 1, 1 = two banks with swap handshake; 0 = single shared bank
- CLK  in  1  rising-edge clock, the only clock
- RST  in  1  reset, asynchronous, active-high
- A_ADDR  in  ADDR_W  port A word address (engine side)
- A_DIN  in  DATA_W  port A write data
- A_WEN  in  1  port A write enable
- A_DOUT  out  DATA_W  port A registered read data
- A_COMMIT  in  1  one-cycle pulse: fill bank complete, request swap
- B_ADDR  in  ADDR_W  port B word address (host side)
- B_DIN  in  DATA_W  port B write data
- B_WEN  in  1  port B write enable
- B_DOUT  out  DATA_W  port B registered read data
- B_LOCK  in  1  level: host is reading the stable bank, swap must wait
- B_ACK  in  1  one-cycle pulse: clears B_FRESH and OVERRUN
- BANK_SEL  out  1  physical bank currently used as fill bank (port A)
- SWAP_PEND  out  1  commit accepted, swap deferred by B_LOCK
- B_FRESH  out  1  new stable bank available, not yet acknowledged
- OVERRUN  out  1  sticky: commit arrived while a swap was already pending
- COLLISION  out  1  one-cycle pulse: simultaneous A/B write to same physical word

## Operation
- Storage: 2 x 2^ADDR_W words when PINGPONG=1; 1 x 2^ADDR_W words when PINGPONG=0. Contents are not reset.
- Port A physical bank is BANK_SEL. Port B physical bank is ~BANK_SEL. Both ports read and write their own bank.
- Reads on both ports are synchronous, read-first. A read of a word written in the same cycle, by either port, returns the old data.
- Swap: BANK_SEL toggles, SWAP_PEND clears, B_FRESH sets.
- Commit with SWAP_PEND=0 and B_LOCK=0: swap at the next edge.
- Commit with SWAP_PEND=0 and B_LOCK=1: SWAP_PEND sets.
- SWAP_PEND=1: swap at the first edge closing a cycle with B_LOCK=0.
- Commit while SWAP_PEND=1: OVERRUN sets and no extra swap is queued. This holds even if the pending swap executes in that same cycle. Port A keeps writing the same fill bank.
- B_ACK clears B_FRESH and OVERRUN. Set has priority over B_ACK in the same cycle.
- PINGPONG=0:
  - A_COMMIT and B_LOCK are ignored.
  - BANK_SEL, SWAP_PEND, B_FRESH and OVERRUN are held 0.
  - Both ports use bank 0.
  - If A_WEN, B_WEN and A_ADDR==B_ADDR in the same cycle, port A data is stored and COLLISION pulses high for the following cycle.
- PINGPONG=1: COLLISION is held 0, because the ports are always on different banks.

## Timing
- Reset values: A_DOUT=0, B_DOUT=0, BANK_SEL=0, SWAP_PEND=0, B_FRESH=0, OVERRUN=0, COLLISION=0. Reset mid-operation abandons any pending swap.
- Read latency is 1 cycle: address in cycle n, data valid in cycle n+1, held until the next read.
- Write latency is 1 cycle: data written in cycle n is readable from cycle n+1.
- Commit boundary:
  - A writes in the commit cycle n belong to the committed buffer.
  - A accesses from n+1 go to the new fill bank when the swap is immediate.
  - B reads issued in cycle n return old stable data.
  - B reads issued from n+1 return the newly committed data.
- BANK_SEL, SWAP_PEND, B_FRESH, OVERRUN and COLLISION are registered and change only on CLK edges.
- All control inputs are sampled on the CLK rising edge. A_COMMIT and B_ACK are counted once per high cycle.

## Test plan
- Reset and fill:
  - Stimulus: PINGPONG=1, reset; A writes 0xA000+i to addresses 0..31; commit with B_LOCK=0.
  - Response: BANK_SEL=1 and B_FRESH=1 the cycle after commit; B reads addresses 0..31 return 0xA000+i at 1-cycle latency.
- Deferred swap:
  - Stimulus: B_LOCK=1, commit; hold lock 10 cycles, then release.
  - Response: SWAP_PEND=1 and BANK_SEL unchanged for all 10 cycles; BANK_SEL toggles and SWAP_PEND=0 at the edge closing the first unlocked cycle.
- Overrun:
  - Stimulus: B_LOCK=1, commit twice.
  - Response: OVERRUN=1, exactly one swap after unlock.
  - Stimulus: then B_ACK.
  - Response: OVERRUN=0 and B_FRESH=0.
- Commit-cycle write:
  - Stimulus: A writes 0x1234 to address 7 in the same cycle as the commit.
  - Response: B reads 0x1234 at address 7 after the swap.
- Shared-mode collision:
  - Stimulus: PINGPONG=0; A writes 0x5555 and B writes 0xAAAA to address 3 in the same cycle.
  - Response: COLLISION high for exactly one cycle; both ports later read 0x5555.
- Read-first and async reset:
  - Stimulus: write 0xBEEF while B reads the same address.
  - Response: B_DOUT shows old data, then 0xBEEF on the next read.
  - Stimulus: assert RST mid-cycle while SWAP_PEND=1.
  - Response: all outputs 0 immediately, without waiting for a CLK edge.
